// File: rtl/complex_alu_exec_pkg.sv
// Shared opcodes, state encoding and width defaults for the complex ALU
// execution unit and its controller.
package complex_alu_exec_pkg;

  localparam int CW_DEF = 32;
  localparam int DW_DEF = 2 * CW_DEF;

  localparam logic [3:0] OP_LDA  = 4'b0000;
  localparam logic [3:0] OP_LDB  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_CMUL = 4'b0100;
  localparam logic [3:0] OP_RMUL = 4'b0110;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_MODA = 4'b1001;
  localparam logic [3:0] OP_MODB = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Final EXEC step index; EXEC lasts last_step+1 cycles.
  function automatic logic [2:0] last_step(input logic [3:0] op);
    case (op)
      OP_CMUL:          last_step = 3'd4;
      OP_RMUL:          last_step = 3'd1;
      OP_MODA, OP_MODB: last_step = 3'd2;
      default:          last_step = 3'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_CMUL,
      OP_RMUL, OP_EQ, OP_MODA, OP_MODB: is_legal = 1'b1;
      default:                          is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/complex_alu_exec_mul.sv
// Registered signed CW x CW multiplier shared by all multiply-based ops.
// No reset: the product is only consumed in the step after it was issued.
module mul_s32_reg
  import complex_alu_exec_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic                   clock,
  input  logic signed [CW-1:0]   a,
  input  logic signed [CW-1:0]   b,
  output logic signed [2*CW-1:0] p
);

  always_ff @(posedge clock) begin
    p <= a * b;
  end

endmodule

// File: rtl/complex_alu_exec.sv
// Complex-number execution unit: operand registers A/B, op sequencing and
// result/strobe generation toward the operation controller.
//
//   state   | meaning
//   IDLE    | waiting for start; opr/data_in captured on accept
//   EXEC    | stepping the op sequence; result written on the last step
//   DONE    | done pulse, out_alux valid; start ignored
module complex_alu_exec
  import complex_alu_exec_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int DW = 2 * CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    opr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] out_alux,
  output logic          done,
  output logic          busy,
  output logic          err
);

  state_t              state;
  logic [3:0]          op_r;
  logic [DW-1:0]       data_r;
  logic [DW-1:0]       a_r;
  logic [DW-1:0]       b_r;
  logic [2:0]          step;
  logic signed [2*CW:0] acc;
  logic [CW-1:0]       re_r;

  logic signed [CW-1:0]   ar, ai, br, bi;
  logic signed [CW-1:0]   mul_a, mul_b;
  logic signed [2*CW-1:0] p;
  logic signed [2*CW:0]   p_ext;
  logic [DW-1:0]          res;

  assign ar    = a_r[DW-1:CW];
  assign ai    = a_r[CW-1:0];
  assign br    = b_r[DW-1:CW];
  assign bi    = b_r[CW-1:0];
  assign p_ext = {p[2*CW-1], p};

  mul_s32_reg #(.CW(CW)) u_mul (
    .clock (clock),
    .a     (mul_a),
    .b     (mul_b),
    .p     (p)
  );

  // Multiplier issue schedule: CMUL issues ArBr, AiBi, ArBi, AiBr in steps 0-3.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (op_r)
      OP_CMUL: begin
        case (step)
          3'd0:    begin mul_a = ar; mul_b = br; end
          3'd1:    begin mul_a = ai; mul_b = bi; end
          3'd2:    begin mul_a = ar; mul_b = bi; end
          default: begin mul_a = ai; mul_b = br; end
        endcase
      end
      OP_RMUL: begin mul_a = ar; mul_b = br; end
      OP_MODA: begin
        mul_a = (step == 3'd0) ? ar : ai;
        mul_b = mul_a;
      end
      OP_MODB: begin
        mul_a = (step == 3'd0) ? br : bi;
        mul_b = mul_a;
      end
      default: ;
    endcase
  end

  always_comb begin
    res = out_alux;
    case (op_r)
      OP_LDA, OP_LDB:   res = data_r;
      OP_ADD:           res = {CW'(ar + br), CW'(ai + bi)};
      OP_SUB:           res = {CW'(ar - br), CW'(ai - bi)};
      OP_CMUL:          res = {re_r, CW'(acc + p_ext)};
      OP_RMUL:          res = p;
      OP_EQ:            res = {{(DW-1){1'b0}}, (a_r == b_r)};
      OP_MODA, OP_MODB: res = DW'(acc + p_ext);
      default:          ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_r     <= '0;
      data_r   <= '0;
      a_r      <= '0;
      b_r      <= '0;
      step     <= '0;
      acc      <= '0;
      re_r     <= '0;
      out_alux <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r   <= opr;
            data_r <= data_in;
            step   <= '0;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          step <= step + 3'd1;
          if (op_r == OP_CMUL) begin
            case (step)
              3'd1:    acc  <= p_ext;
              3'd2:    re_r <= CW'(acc - p_ext);
              3'd3:    acc  <= p_ext;
              default: ;
            endcase
          end
          if ((op_r == OP_MODA || op_r == OP_MODB) && step == 3'd1)
            acc <= p_ext;
          if (step == last_step(op_r)) begin
            out_alux <= res;
            err      <= ~is_legal(op_r);
            done     <= 1'b1;
            state    <= ST_DONE;
            if (op_r == OP_LDA) a_r <= data_r;
            if (op_r == OP_LDB) b_r <= data_r;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_alu_exec.sv
// Scoreboard bench for complex_alu_exec: directed plan plus random ops
// against an arithmetic reference model of the operand registers.
module tb_complex_alu_exec;
  import complex_alu_exec_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  opr;
  logic [63:0] data_in;
  logic [63:0] out_alux;
  logic        done, busy, err;

  complex_alu_exec dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .opr      (opr),
    .data_in  (data_in),
    .out_alux (out_alux),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] out;
    logic        err;
    int          cyc;
    logic [3:0]  op;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] mA, mB, mout;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] cx(input logic [31:0] re, input logic [31:0] im);
    return {re, im};
  endfunction

  // Reference model: plain integer arithmetic on the complex components.
  task automatic model(input logic [3:0] op, input logic [63:0] d,
                       output logic [63:0] r, output logic e, output int lat);
    int ar, ai, br, bi;
    logic [31:0] tr, ti;
    ar = mA[63:32]; ai = mA[31:0];
    br = mB[63:32]; bi = mB[31:0];
    e = 1'b0; r = mout; lat = 2;
    case (op)
      4'd0: begin mA = d; r = d; end
      4'd1: begin mB = d; r = d; end
      4'd2: begin tr = ar + br; ti = ai + bi; r = {tr, ti}; end
      4'd3: begin tr = ar - br; ti = ai - bi; r = {tr, ti}; end
      4'd4: begin
        tr = 32'(longint'(ar) * br - longint'(ai) * bi);
        ti = 32'(longint'(ar) * bi + longint'(ai) * br);
        r = {tr, ti}; lat = 6;
      end
      4'd6:  begin r = longint'(ar) * longint'(br); lat = 3; end
      4'd8:  r = (mA == mB) ? 64'd1 : 64'd0;
      4'd9:  begin r = longint'(ar) * ar + longint'(ai) * ai; lat = 4; end
      4'd10: begin r = longint'(br) * br + longint'(bi) * bi; lat = 4; end
      default: e = 1'b1;
    endcase
    mout = r;
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [63:0] d, input int base);
    exp_t x;
    int lat;
    model(op, d, x.out, x.err, lat);
    x.cyc = base + lat;
    x.op  = op;
    sbq.push_back(x);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clock);
    while (busy && k < 40) begin
      @(negedge clock);
      k++;
    end
    n_vec++;
    if (busy) begin
      n_bad++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy, k);
    end
  endtask

  // Called at a negedge with the DUT idle.
  task automatic do_op(input logic [3:0] op, input logic [63:0] d);
    opr = op; data_in = d; start = 1'b1;
    push_exp(op, d, cyc);
    @(posedge clock);
    #1 start = 1'b0;
    wait_idle();
  endtask

  always @(negedge clock) begin
    if (!reset && done) begin
      chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
      if (sbq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion pending");
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk($sformatf("out_op%0d", x.op), out_alux, x.out);
        chk($sformatf("err_op%0d", x.op), {63'd0, err}, {63'd0, x.err});
        chk($sformatf("latency_op%0d", x.op), 64'(cyc), 64'(x.cyc));
      end
    end
    prev_done = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    int base;
    reset = 1'b1; start = 1'b0; opr = '0; data_in = '0;
    mA = '0; mB = '0; mout = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err",  {63'd0, err},  64'd0);
    chk("rst_out",  out_alux,      64'd0);
    reset = 1'b0;

    do_op(OP_LDA, cx(32'd5, 32'd6));
    do_op(OP_LDB, cx(32'd7, 32'd8));

    // Reset while CMUL is in step 2.
    opr = OP_CMUL; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_out",  out_alux,      64'd0);
    mA = '0; mB = '0; mout = '0;
    reset = 1'b0;
    @(negedge clock);
    do_op(OP_MODB, 64'd0);
    do_op(OP_EQ, 64'd0);

    do_op(OP_LDA, cx(32'd3, 32'd4));
    do_op(OP_LDB, cx(32'd1, -32'sd2));
    do_op(OP_ADD, 64'd0);
    do_op(OP_SUB, 64'd0);
    do_op(OP_CMUL, 64'd0);
    do_op(OP_RMUL, 64'd0);
    do_op(OP_MODA, 64'd0);
    do_op(OP_LDB, cx(32'd3, 32'd4));
    do_op(OP_EQ, 64'd0);
    do_op(OP_LDB, cx(32'd3, 32'd5));
    do_op(OP_EQ, 64'd0);

    do_op(OP_LDA, cx(32'h7FFF_FFFF, 32'd0));
    do_op(OP_LDB, cx(32'd1, 32'd0));
    do_op(OP_ADD, 64'd0);
    do_op(OP_LDA, cx(32'h8000_0000, 32'd0));
    do_op(OP_LDB, cx(32'h8000_0000, 32'd0));
    do_op(OP_RMUL, 64'd0);
    do_op(OP_MODA, 64'd0);

    do_op(4'b0101, {$urandom, $urandom});
    do_op(OP_LDA, cx(32'd9, -32'sd9));

    // start held across two ADDs: second accept only after DONE.
    opr = OP_ADD; start = 1'b1;
    base = cyc;
    push_exp(OP_ADD, 64'd0, base);
    push_exp(OP_ADD, 64'd0, base + 3);
    @(posedge clock);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      pat[5-i] = busy;
    end
    start = 1'b0;
    chk("held_start_busy_pattern", {58'd0, pat}, 64'b110110);
    wait_idle();

    for (int n = 0; n < 60; n++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      do_op(rop, {$urandom, $urandom});
    end

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clock);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
